// File: rtl/occupancy_grid_rmw.sv
// Occupancy grid of unsigned log-odds cells: saturating read-modify-write updates on
// port A, independent registered reads on port B, and a full-grid prior fill on clear.
module occupancy_grid_rmw #(
  parameter int X_WIDTH       = 5,
  parameter int Y_WIDTH       = 4,
  parameter int CELL_WIDTH    = 8,
  parameter int INIT_VALUE    = 128,
  parameter int OCC_INC       = 20,
  parameter int FREE_DEC      = 8,
  parameter int OCC_THRESHOLD = 160
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  zero_memory,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [X_WIDTH-1:0]    upd_x,
  input  logic [Y_WIDTH-1:0]    upd_y,
  input  logic                  upd_free,
  input  logic                  rd_en,
  input  logic [X_WIDTH-1:0]    rd_x,
  input  logic [Y_WIDTH-1:0]    rd_y,
  output logic [CELL_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_occupied,
  output logic                  busy
);

  localparam int ADDR_WIDTH = X_WIDTH + Y_WIDTH;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  localparam logic [1:0] ST_CLEAR     = 2'd0;
  localparam logic [1:0] ST_IDLE      = 2'd1;
  localparam logic [1:0] ST_RMW_READ  = 2'd2;
  localparam logic [1:0] ST_RMW_WRITE = 2'd3;

  localparam logic [CELL_WIDTH-1:0] INIT_CELL    = CELL_WIDTH'(INIT_VALUE);
  localparam logic [CELL_WIDTH:0]   INC_EXT      = (CELL_WIDTH+1)'(OCC_INC);
  localparam logic [CELL_WIDTH:0]   DEC_EXT      = (CELL_WIDTH+1)'(FREE_DEC);
  localparam logic [CELL_WIDTH:0]   CELL_MAX_EXT = {1'b0, {CELL_WIDTH{1'b1}}};
  localparam logic [CELL_WIDTH:0]   THRESH_EXT   = (CELL_WIDTH+1)'(OCC_THRESHOLD);

  logic [CELL_WIDTH-1:0] mem [DEPTH];

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [ADDR_WIDTH-1:0] upd_addr_q, upd_addr_d;
  logic                  upd_free_q, upd_free_d;
  logic [CELL_WIDTH-1:0] operand_q, operand_d;
  logic [CELL_WIDTH-1:0] porta_data_q;
  logic                  upd_fire;

  logic [CELL_WIDTH:0]   occ_sum;
  logic [CELL_WIDTH-1:0] new_cell;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [CELL_WIDTH-1:0] mem_wdata;

  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [CELL_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;
  logic                  rd_occupied_q;

  assign rd_addr     = {rd_y, rd_x};
  assign busy        = (state_q == ST_CLEAR);
  assign upd_ready   = (state_q == ST_IDLE) && !zero_memory;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign rd_occupied = rd_occupied_q;

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    upd_addr_d = upd_addr_q;
    upd_free_d = upd_free_q;
    operand_d  = operand_q;
    upd_fire   = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        if (clr_cnt_q == '1) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        // A clear request wins over a simultaneous update, which is dropped.
        if (zero_memory) begin
          clr_cnt_d = '0;
          state_d   = ST_CLEAR;
        end else if (upd_valid) begin
          upd_fire   = 1'b1;
          upd_addr_d = {upd_y, upd_x};
          upd_free_d = upd_free;
          state_d    = ST_RMW_READ;
        end
      end
      ST_RMW_READ: begin
        operand_d = porta_data_q;
        state_d   = ST_RMW_WRITE;
      end
      ST_RMW_WRITE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // Saturating arithmetic is done one bit wider so neither direction can wrap.
  always_comb begin
    occ_sum = {1'b0, operand_q} + INC_EXT;
    if (upd_free_q) begin
      new_cell = ({1'b0, operand_q} < DEC_EXT) ? '0 : operand_q - DEC_EXT[CELL_WIDTH-1:0];
    end else begin
      new_cell = (occ_sum > CELL_MAX_EXT) ? CELL_MAX_EXT[CELL_WIDTH-1:0] : occ_sum[CELL_WIDTH-1:0];
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_cnt_q;
    mem_wdata = INIT_CELL;
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        mem_we = 1'b1;
      end else if (state_q == ST_RMW_WRITE) begin
        mem_we    = 1'b1;
        mem_waddr = upd_addr_q;
        mem_wdata = new_cell;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    upd_addr_q <= upd_addr_d;
    upd_free_q <= upd_free_d;
    operand_q  <= operand_d;
  end

  // Port A: write side and the RMW operand fetch.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    if (upd_fire) begin
      porta_data_q <= mem[{upd_y, upd_x}];
    end
  end

  // Port B samples the array before any same-edge port-A write lands.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
      rd_occupied_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_data_q     <= mem[rd_addr];
        rd_occupied_q <= ({1'b0, mem[rd_addr]} >= THRESH_EXT);
      end
    end
  end

endmodule

// File: tb/tb_occupancy_grid_rmw.sv
// Randomised scoreboard bench for occupancy_grid_rmw: a cell-array reference model
// predicts every read, plus busy/upd_ready each cycle.
module tb_occupancy_grid_rmw;

  localparam int CLEAR_CYCLES = 512;
  localparam int INIT_VAL     = 128;
  localparam int INC          = 20;
  localparam int DEC          = 8;
  localparam int CELL_MAX     = 255;
  localparam int THRESH       = 160;

  logic       clock = 1'b0;
  logic       reset;
  logic       zero_memory;
  logic       upd_valid;
  logic       upd_ready;
  logic [4:0] upd_x;
  logic [3:0] upd_y;
  logic       upd_free;
  logic       rd_en;
  logic [4:0] rd_x;
  logic [3:0] rd_y;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_occupied;
  logic       busy;

  occupancy_grid_rmw dut (
    .clock       (clock),
    .reset       (reset),
    .zero_memory (zero_memory),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .upd_x       (upd_x),
    .upd_y       (upd_y),
    .upd_free    (upd_free),
    .rd_en       (rd_en),
    .rd_x        (rd_x),
    .rd_y        (rd_y),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_occupied (rd_occupied),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int edge_i;
    int val;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  int      model [512];
  int      cur_edge    = 0;
  int      clear_done  = 0;
  int      last_accept = -10;
  int      reset_edge  = -10;
  bit      pend_valid  = 1'b0;
  int      pend_addr, pend_val, pend_due;
  bit      rand_reads  = 1'b0;
  int      n_compared  = 0;
  int      n_mismatched = 0;

  task automatic check(input string name, input int act, input int exp);
    n_compared++;
    if (act != exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cur_edge);
    end
  endtask

  function automatic int apply_update(input int cur, input bit free);
    if (free) return (cur < DEC) ? 0 : cur - DEC;
    return (cur + INC > CELL_MAX) ? CELL_MAX : cur + INC;
  endfunction

  task automatic fill_model();
    for (int i = 0; i < 512; i++) model[i] = INIT_VAL;
  endtask

  // One clock: predict reads issued at this edge, then advance the model past it.
  task automatic tick();
    int e;
    int a;
    bit idle;
    e    = cur_edge + 1;
    idle = (cur_edge >= clear_done) && (cur_edge >= last_accept + 2);
    if (rand_reads) begin
      rd_en = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 2) == 0) begin
        rd_x = upd_x;
        rd_y = upd_y;
      end else begin
        rd_x = 5'($urandom_range(0, 31));
        rd_y = 4'($urandom_range(0, 15));
      end
    end
    if (rd_en && !reset) begin
      a = int'({rd_y, rd_x});
      exp_q.push_back('{e, (pend_valid && pend_addr == a && pend_due < e) ? pend_val : model[a]});
    end
    @(posedge clock);
    cur_edge = e;
    if (reset) begin
      pend_valid  = 1'b0;
      clear_done  = e + CLEAR_CYCLES;
      last_accept = -10;
      reset_edge  = e;
      fill_model();
    end else begin
      if (pend_valid && pend_due == e) begin
        model[pend_addr] = pend_val;
        pend_valid = 1'b0;
      end
      if (idle && zero_memory) begin
        clear_done = e + CLEAR_CYCLES;
        fill_model();
      end else if (idle && upd_valid) begin
        a           = int'({upd_y, upd_x});
        pend_valid  = 1'b1;
        pend_addr   = a;
        pend_val    = apply_update(model[a], upd_free);
        pend_due    = e + 2;
        last_accept = e;
      end
    end
    #1;
  endtask

  task automatic do_update(input logic [4:0] x, input logic [3:0] y, input bit free,
                           output int acc_edge);
    upd_valid = 1'b1;
    upd_x     = x;
    upd_y     = y;
    upd_free  = free;
    acc_edge  = -1;
    for (int n = 0; n < 2000 && acc_edge < 0; n++) begin
      tick();
      if (last_accept == cur_edge) acc_edge = cur_edge;
    end
    upd_valid = 1'b0;
    if (acc_edge < 0) check("upd_accept_timeout", int'(upd_ready), 1);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 1000 && !(cur_edge >= clear_done && cur_edge >= last_accept + 2); n++) tick();
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 600) begin
      tick();
      n++;
    end
  endtask

  task automatic read_cell(input logic [4:0] x, input logic [3:0] y);
    rd_en = 1'b1;
    rd_x  = x;
    rd_y  = y;
    tick();
    rd_en = 1'b0;
    tick();
  endtask

  // Monitor: pops one read expectation per rd_valid and tracks busy/upd_ready each cycle.
  always @(negedge clock) begin
    rd_exp_t ex;
    bit      exp_busy;
    if (cur_edge > 0) begin
      exp_busy = (cur_edge < clear_done);
      check("busy", int'(busy), int'(exp_busy));
      check("upd_ready", int'(upd_ready),
            int'(!exp_busy && cur_edge >= last_accept + 2 && !zero_memory));
      if (reset_edge == cur_edge) begin
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_rd_occupied", int'(rd_occupied), 0);
      end
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          check("rd_spurious_valid", int'(rd_valid), 0);
        end else begin
          ex = exp_q.pop_front();
          check("rd_latency", cur_edge, ex.edge_i);
          check("rd_data", int'(rd_data), ex.val);
          check("rd_occupied", int'(rd_occupied), int'(ex.val >= THRESH));
        end
      end else if (exp_q.size() != 0 && exp_q[0].edge_i <= cur_edge) begin
        ex = exp_q.pop_front();
        check("rd_valid_missing", int'(rd_valid), 1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, edge %0d", cur_edge);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a1, a2, n;
    reset       = 1'b1;
    zero_memory = 1'b0;
    upd_valid   = 1'b0;
    upd_x       = '0;
    upd_y       = '0;
    upd_free    = 1'b0;
    rd_en       = 1'b0;
    rd_x        = '0;
    rd_y        = '0;
    fill_model();

    // Power-up clear and full prior readback
    tick();
    tick();
    reset = 1'b0;
    count_busy(n);
    check("clear_len_after_reset", n, CLEAR_CYCLES);
    for (int i = 0; i < 512; i++) begin
      rd_en = 1'b1;
      {rd_y, rd_x} = 9'(i);
      tick();
    end
    rd_en = 1'b0;
    tick();

    // Back-to-back occupied updates with upd_valid held
    do_update(5'd3, 4'd2, 1'b0, a1);
    do_update(5'd3, 4'd2, 1'b0, a2);
    check("accept_gap", a2 - a1, 3);
    wait_idle();
    read_cell(5'd3, 4'd2);
    read_cell(5'd2, 4'd3);

    // Saturation at both ends
    for (int i = 0; i < 7; i++) do_update(5'd31, 4'd15, 1'b0, a1);
    for (int i = 0; i < 18; i++) do_update(5'd0, 4'd0, 1'b1, a1);
    wait_idle();
    read_cell(5'd31, 4'd15);
    read_cell(5'd0, 4'd0);

    // zero_memory during an in-flight update is ignored
    do_update(5'd10, 4'd4, 1'b0, a1);
    zero_memory = 1'b1;
    tick();
    tick();
    zero_memory = 1'b0;
    wait_idle();
    read_cell(5'd10, 4'd4);

    // zero_memory together with upd_valid in IDLE: clear wins, update dropped
    zero_memory = 1'b1;
    upd_valid   = 1'b1;
    upd_x       = 5'd9;
    upd_y       = 4'd9;
    upd_free    = 1'b0;
    tick();
    zero_memory = 1'b0;
    upd_valid   = 1'b0;
    count_busy(n);
    check("clear_len_after_zero", n, CLEAR_CYCLES);
    read_cell(5'd3, 4'd2);
    read_cell(5'd31, 4'd15);
    read_cell(5'd0, 4'd0);
    read_cell(5'd9, 4'd9);

    // Reset during RMW_READ, then again part-way through the clear
    do_update(5'd5, 4'd5, 1'b0, a1);
    wait_idle();
    do_update(5'd5, 4'd5, 1'b0, a1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    count_busy(n);
    check("clear_len_after_rmw_reset", n, CLEAR_CYCLES);
    read_cell(5'd5, 4'd5);
    do_update(5'd5, 4'd5, 1'b0, a1);
    wait_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    count_busy(n);
    check("clear_len_after_mid_clear_reset", n, CLEAR_CYCLES);
    read_cell(5'd5, 4'd5);

    // Read colliding with the RMW write of the same cell returns the old value
    do_update(5'd7, 4'd1, 1'b0, a1);
    tick();
    rd_en = 1'b1;
    rd_x  = 5'd7;
    rd_y  = 4'd1;
    tick();
    tick();
    rd_en = 1'b0;
    tick();

    // Random updates on a small patch with random concurrent reads
    rand_reads = 1'b1;
    for (int i = 0; i < 200; i++) begin
      do_update(5'($urandom_range(0, 3)), 4'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), a1);
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end
    rand_reads = 1'b0;
    rd_en = 1'b0;
    wait_idle();
    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 2; y++) read_cell(5'(x), 4'(y));
    end

    tick();
    tick();
    check("rd_leftover_expectations", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
